// File: rtl/sha256_job_arbiter.sv
// Round-robin arbiter sharing one SHA-256 core among NUM_REQ requesters,
// with per-job timeout and abort handling.
module sha256_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*16-1:0] req_msg_addr,
  input  logic [NUM_REQ*16-1:0] req_out_addr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_done,
  output logic [NUM_REQ-1:0]    rsp_err,
  output logic                  core_start,
  output logic [15:0]           core_message_addr,
  output logic [15:0]           core_output_addr,
  input  logic                  core_done,
  output logic                  busy,
  output logic [2:0]            owner
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE, ABORT} state_t;

  localparam logic [3:0]         NREQ     = 4'(NUM_REQ);
  localparam logic [15:0]        TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t             state;
  logic [2:0]         rr_ptr;
  logic [15:0]        timer, timer_inc;
  logic [NUM_REQ-1:0] rot;
  logic               grant_vld;
  logic [3:0]         gsum;
  logic [2:0]         grant;
  logic [15:0]        msg_sel, out_sel;
  logic [3:0]         own_inc;
  logic [2:0]         next_ptr;
  logic               timeout_hit;

  // Rotate so bit 0 is rr_ptr; the lowest set bit of the rotated vector wins.
  always_comb begin
    rot       = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    grant_vld = 1'b0;
    gsum      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_vld = 1'b1;
        gsum      = {1'b0, rr_ptr} + 4'(k);
      end
    end
    if (gsum >= NREQ) gsum = gsum - NREQ;
    grant = gsum[2:0];
  end

  always_comb begin
    msg_sel = '0;
    out_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant == 3'(k)) begin
        msg_sel = req_msg_addr[16*k +: 16];
        out_sel = req_out_addr[16*k +: 16];
      end
    end
  end

  assign own_inc     = {1'b0, owner} + 4'd1;
  assign next_ptr    = (own_inc == NREQ) ? 3'd0 : own_inc[2:0];
  assign timer_inc   = (timer == 16'hFFFF) ? timer : timer + 16'd1;
  assign timeout_hit = (timer_inc >= TMO_LAST);

  // Handshake must be same-cycle, so ready is decoded from the state register.
  assign req_ready = (state == IDLE && core_done && grant_vld && !reset) ? (ONE << grant) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      owner             <= '0;
      timer             <= '0;
      core_start        <= 1'b0;
      rsp_done          <= '0;
      rsp_err           <= '0;
      core_message_addr <= '0;
      core_output_addr  <= '0;
    end else begin
      core_start <= 1'b0;
      rsp_done   <= '0;
      rsp_err    <= '0;
      case (state)
        IDLE: if (core_done && grant_vld) begin
          owner             <= grant;
          core_message_addr <= msg_sel;
          core_output_addr  <= out_sel;
          core_start        <= 1'b1;
          state             <= LAUNCH;
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        // The core's done is high while idle; wait to see it drop before trusting a rise.
        WAIT_BUSY: begin
          timer <= timer_inc;
          if (!core_done) state <= WAIT_DONE;
          else if (timeout_hit) begin
            rsp_done <= ONE << owner;
            rsp_err  <= ONE << owner;
            state    <= ABORT;
          end
        end
        WAIT_DONE: begin
          timer <= timer_inc;
          if (core_done) begin
            rsp_done <= ONE << owner;
            state    <= COMPLETE;
          end else if (timeout_hit) begin
            rsp_done <= ONE << owner;
            rsp_err  <= ONE << owner;
            state    <= ABORT;
          end
        end
        COMPLETE: begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        ABORT: if (core_done) begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Bench for sha256_job_arbiter: vector table, hand-written corner sequences and
// random jobs checked against a job-level round-robin model.
module tb_sha256_job_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*16-1:0] req_msg_addr, req_out_addr;
  logic            core_done, core_lvl, hold_low;
  logic [N-1:0]    req_ready, rsp_done, rsp_err;
  logic            core_start, busy;
  logic [15:0]     core_message_addr, core_output_addr;
  logic [2:0]      owner;
  logic [N-1:0]    t_req_ready, t_rsp_done, t_rsp_err;
  logic            t_core_start, t_busy;
  logic [15:0]     t_msg, t_out;
  logic [2:0]      t_owner;

  assign core_done = core_lvl & ~hold_low;

  sha256_job_arbiter #(.NUM_REQ(N), .TIMEOUT(4096)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_msg_addr(req_msg_addr),
    .req_out_addr(req_out_addr), .req_ready(req_ready), .rsp_done(rsp_done),
    .rsp_err(rsp_err), .core_start(core_start), .core_message_addr(core_message_addr),
    .core_output_addr(core_output_addr), .core_done(core_done), .busy(busy), .owner(owner));

  sha256_job_arbiter #(.NUM_REQ(N), .TIMEOUT(16)) dut_t (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_msg_addr(req_msg_addr),
    .req_out_addr(req_out_addr), .req_ready(t_req_ready), .rsp_done(t_rsp_done),
    .rsp_err(t_rsp_err), .core_start(t_core_start), .core_message_addr(t_msg),
    .core_output_addr(t_out), .core_done(core_done), .busy(t_busy), .owner(t_owner));

  int n_chk = 0, n_fail = 0;
  int core_pre = 0, core_low = 1, ptr = 0;
  logic use_t = 1'b0;
  logic start_sel;
  logic [15:0] msg [N];
  logic [15:0] outa [N];
  assign start_sel = use_t ? t_core_start : core_start;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Core model: done stays high core_pre cycles after start, then low core_low cycles.
  initial begin
    core_lvl = 1'b1;
    forever begin
      @(negedge clk);
      if (start_sel) begin
        repeat (core_pre + 1) @(posedge clk);
        #1 core_lvl = 1'b0;
        repeat (core_low) @(posedge clk);
        #1 core_lvl = 1'b1;
      end
    end
  end

  function automatic logic [N-1:0] rr_grant(input logic [N-1:0] v, input int p);
    logic [N-1:0] oh;
    oh = '0;
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N] && oh == '0) oh[(p + k) % N] = 1'b1;
    end
    return oh;
  endfunction

  function automatic int idx_of(input logic [N-1:0] oh);
    for (int k = 0; k < N; k++) if (oh[k]) return k;
    return 0;
  endfunction

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      lat++;
    end while (rsp_done == '0 && lat < 400);
  endtask

  task automatic run_job(input logic [N-1:0] v, input int pre, input int low,
                         input logic [N-1:0] exp_rdy, input int exp_lat, input string nm);
    int g, lat;
    logic [15:0] em, eo;
    logic stray, drift;
    @(posedge clk); #1;
    core_pre = pre;
    core_low = low;
    for (int k = 0; k < N; k++) begin
      msg[k]  = 16'($urandom);
      outa[k] = 16'($urandom);
      req_msg_addr[16*k +: 16] = msg[k];
      req_out_addr[16*k +: 16] = outa[k];
    end
    req_valid = v;
    @(negedge clk);
    chk({nm, " ready"}, 64'(req_ready), 64'(exp_rdy));
    g  = idx_of(exp_rdy);
    em = msg[g];
    eo = outa[g];
    @(posedge clk); #1;
    req_valid    = N'($urandom);
    req_msg_addr = {$urandom, $urandom};
    req_out_addr = {$urandom, $urandom};
    @(negedge clk);
    chk({nm, " start"}, 64'(core_start), 64'(1));
    chk({nm, " owner"}, 64'(owner), 64'(g));
    chk({nm, " msg"}, 64'(core_message_addr), 64'(em));
    chk({nm, " out"}, 64'(core_output_addr), 64'(eo));
    lat = 1; stray = 1'b0; drift = 1'b0;
    while (rsp_done == '0 && lat < 400) begin
      @(posedge clk); #1;
      @(negedge clk);
      lat++;
      if (req_ready != '0 || core_start) stray = 1'b1;
      if (core_message_addr != em || core_output_addr != eo) drift = 1'b1;
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " done"}, 64'(rsp_done), 64'(exp_rdy));
    chk({nm, " err"}, 64'(rsp_err), 64'(0));
    chk({nm, " stray"}, 64'(stray), 64'(0));
    chk({nm, " addr_hold"}, 64'(drift), 64'(0));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk({nm, " done_pulse"}, 64'({busy, rsp_done}), 64'(0));
  endtask

  typedef struct {
    logic [N-1:0] v;
    int           pre;
    int           low;
    logic [N-1:0] rdy;
    int           lat;
  } vec_t;
  vec_t tbl [11];

  initial begin
    int lat, done_at, grant_at, pulses;
    logic [N-1:0] dval, eval, gval, e, v;
    logic stray;
    int pre, low;

    tbl[0]  = '{4'b0100, 0, 150, 4'b0100, 153};
    tbl[1]  = '{4'b1111, 0, 5,   4'b1000, 8};
    tbl[2]  = '{4'b1111, 1, 4,   4'b0001, 8};
    tbl[3]  = '{4'b1111, 2, 3,   4'b0010, 8};
    tbl[4]  = '{4'b1111, 0, 1,   4'b0100, 4};
    tbl[5]  = '{4'b1111, 0, 2,   4'b1000, 5};
    tbl[6]  = '{4'b1111, 3, 2,   4'b0001, 8};
    tbl[7]  = '{4'b0110, 0, 4,   4'b0010, 7};
    tbl[8]  = '{4'b0011, 1, 1,   4'b0001, 5};
    tbl[9]  = '{4'b1000, 0, 6,   4'b1000, 9};
    tbl[10] = '{4'b1111, 2, 2,   4'b0001, 7};

    reset = 1'b1; hold_low = 1'b0;
    req_valid = '1; req_msg_addr = '1; req_out_addr = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 64'(req_ready), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset start", 64'(core_start), 64'(0));
    chk("reset done_err", 64'({rsp_done, rsp_err}), 64'(0));
    chk("reset owner", 64'(owner), 64'(0));
    chk("reset addr", 64'({core_message_addr, core_output_addr}), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0; req_valid = '0;

    foreach (tbl[i]) begin
      run_job(tbl[i].v, tbl[i].pre, tbl[i].low, tbl[i].rdy, tbl[i].lat, $sformatf("tbl%0d", i));
      ptr = (idx_of(tbl[i].rdy) + 1) % N;
    end

    // Core busy at request time: no grant until done returns high.
    @(posedge clk); #1;
    hold_low = 1'b1; req_valid = 4'b0001; core_pre = 0; core_low = 4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("core_busy ready", 64'(req_ready), 64'(0));
      @(posedge clk); #1;
    end
    hold_low = 1'b0;
    @(negedge clk);
    chk("core_idle ready", 64'(req_ready), 64'(rr_grant(4'b0001, ptr)));
    wait_rsp(lat);
    chk("core_idle latency", 64'(lat), 64'(7));
    chk("core_idle done", 64'(rsp_done), 64'(4'b0001));
    ptr = 1;

    for (int j = 0; j < 24; j++) begin
      v   = N'($urandom_range(1, 15));
      e   = rr_grant(v, ptr);
      pre = $urandom_range(0, 3);
      low = $urandom_range(1, 30);
      run_job(v, pre, low, e, 3 + pre + low, "rand");
      ptr = (idx_of(e) + 1) % N;
    end

    // Timeout on the short-timeout instance.
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    use_t = 1'b1; core_pre = 0; core_low = 40;
    @(posedge clk); #1; req_valid = 4'b0011;
    @(negedge clk);
    chk("tmo ready", 64'(t_req_ready), 64'(4'b0001));
    done_at = 0; grant_at = 0; pulses = 0; dval = '0; eval = '0; gval = '0;
    for (int i = 1; i <= 60 && grant_at == 0; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (t_rsp_done != '0) begin
        pulses++;
        if (done_at == 0) begin done_at = i; dval = t_rsp_done; eval = t_rsp_err; end
      end
      if (t_req_ready != '0) begin grant_at = i; gval = t_req_ready; end
    end
    chk("tmo done_cycle", 64'(done_at), 64'(17));
    chk("tmo done", 64'(dval), 64'(4'b0001));
    chk("tmo err", 64'(eval), 64'(4'b0001));
    chk("tmo pulses", 64'(pulses), 64'(1));
    chk("tmo regrant_cycle", 64'(grant_at), 64'(43));
    chk("tmo regrant", 64'(gval), 64'(4'b0010));
    @(posedge clk); #1; req_valid = '0;
    repeat (60) @(posedge clk);
    #1 use_t = 1'b0;

    // Reset in the middle of a job.
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    ptr = 0;
    run_job(4'b0010, 0, 3, rr_grant(4'b0010, ptr), 6, "pre_rst");
    @(posedge clk); #1;
    core_pre = 0; core_low = 30; req_valid = 4'b0100;
    @(negedge clk);
    chk("rst job ready", 64'(req_ready), 64'(4'b0100));
    repeat (8) @(posedge clk);
    #1 reset = 1'b1; req_valid = 4'b1111;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst outs", 64'({req_ready, rsp_done, rsp_err, core_start, owner}), 64'(0));
    chk("rst addr", 64'({core_message_addr, core_output_addr}), 64'(0));
    core_low = 5;
    stray = 1'b0; lat = 0;
    while (!core_done && lat < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      lat++;
      if (rsp_done != '0) stray = 1'b1;
    end
    chk("rst core_idle", 64'(core_done), 64'(1));
    chk("rst no_done", 64'(stray), 64'(0));
    chk("rst regrant", 64'(req_ready), 64'(rr_grant(4'b1111, 0)));
    wait_rsp(lat);
    chk("rst job latency", 64'(lat), 64'(8));
    chk("rst job done", 64'(rsp_done), 64'(4'b0001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
